// File: rtl/fetch_unit.sv
// ButterFly RV32IM instruction fetch stage.
// Owns the fetch PC, issues imem requests and buffers responses for decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o,
  output logic        if_exc_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {
    RUN,
    HALT
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;

  logic [31:0]           pc_mem_q  [FIFO_DEPTH];
  logic [31:0]           ins_mem_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] exc_q;

  logic        credit, fire, drop, push, pop, misal;
  logic [CW:0] used;

  // Outstanding plus buffered may never exceed the FIFO size.
  assign used   = {1'b0, outst_q} + {1'b0, cnt_q};
  assign credit = used < (CW+1)'(FIFO_DEPTH);
  assign misal  = redirect_pc_i[1:0] != 2'b00;

  // Request is gated by rst_ni so it drops the instant reset asserts.
  assign imem_req_o  = rst_ni & (state_q == RUN)
                     & ~redirect_i & credit;
  assign imem_addr_o = fetch_pc_q;

  assign fire = imem_req_o & imem_gnt_i;
  assign drop = redirect_i | (disc_q != '0);
  assign push = imem_rvalid_i & ~drop;

  assign if_valid_o = cnt_q != '0;
  assign pop        = if_valid_o & if_ready_i;
  assign if_pc_o    = pc_mem_q[rptr_q];
  assign if_instr_o = ins_mem_q[rptr_q];
  assign if_exc_o   = exc_q[rptr_q];

  // Next-state: redirect flushes and overrides all normal updates.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    disc_d     = disc_q;
    cnt_d      = cnt_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    outst_d    = outst_q + CW'(fire)
               - CW'(imem_rvalid_i);
    if (redirect_i) begin
      disc_d     = outst_q - CW'(imem_rvalid_i);
      fetch_pc_d = redirect_pc_i;
      resp_pc_d  = redirect_pc_i;
      rptr_d     = '0;
      wptr_d     = misal ? AW'(1) : '0;
      cnt_d      = misal ? CW'(1) : '0;
      state_d    = misal ? HALT : RUN;
    end else begin
      if (imem_rvalid_i && disc_q != '0)
        disc_d = disc_q - CW'(1);
      if (fire)
        fetch_pc_d = fetch_pc_q + 32'd4;
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wptr_d    = wptr_q + AW'(1);
      end
      if (pop)
        rptr_d = rptr_q + AW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  // State, counters and FIFO storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      disc_q     <= '0;
      cnt_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      exc_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem_q[i]  <= '0;
        ins_mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      disc_q     <= disc_d;
      cnt_q      <= cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      if (redirect_i && misal) begin
        pc_mem_q[0]  <= redirect_pc_i;
        ins_mem_q[0] <= NOP;
        exc_q[0]     <= 1'b1;
      end else if (push) begin
        pc_mem_q[wptr_q]  <= resp_pc_q;
        ins_mem_q[wptr_q] <= imem_rdata_i;
        exc_q[wptr_q]     <= 1'b0;
      end
    end
  end

  // A response with nothing outstanding is a memory protocol error.
  rvalid_outst_a: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    imem_rvalid_i |-> outst_q != '0);

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit.
// Randomized memory/decode traffic against an epoch-based stream model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        if_valid_o;
  logic        if_ready_i = 1'b0;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic        if_exc_o;

  fetch_unit #(
    .RESET_PC  (RESET_PC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .if_valid_o   (if_valid_o),
    .if_ready_i   (if_ready_i),
    .if_pc_o      (if_pc_o),
    .if_instr_o   (if_instr_o),
    .if_exc_o     (if_exc_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    int          ep;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        exc;
  } pkt_t;

  req_t pend_q[$];
  pkt_t exp_q[$];

  int          checks = 0;
  int          errors = 0;
  int          delivered = 0;
  int          epoch = 0;
  bit          halted = 1'b0;
  logic [31:0] model_pc = RESET_PC;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk32(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%b exp=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check request side just before the
  // edge, then advance the stream model just after it.
  task automatic cycle(input bit rd, input logic [31:0] tgt, input bit g,
                       input int rvm, input bit rdy);
    bit   rv;
    bit   rq;
    bit   exp_req;
    req_t e;
    pkt_t p;
    @(negedge clk_i);
    redirect_i    = rd;
    redirect_pc_i = tgt;
    imem_gnt_i    = g;
    if_ready_i    = rdy;
    rv = (pend_q.size() > 0) &&
         (rvm == 1 || (rvm == 2 && $urandom_range(0, 1) == 1));
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? mem_word(pend_q[0].addr) : 32'h0;
    #3;
    exp_req = !halted && !rd &&
              (pend_q.size() + exp_q.size() < DEPTH);
    chk1("req", imem_req_o, exp_req);
    chk32("addr", imem_addr_o, model_pc);
    rq = imem_req_o;
    @(posedge clk_i);
    #1;
    if (rv) begin
      e = pend_q.pop_front();
      if (e.ep == epoch && !rd) begin
        p.pc  = e.addr;
        p.ins = mem_word(e.addr);
        p.exc = 1'b0;
        exp_q.push_back(p);
      end
    end
    if (rq && g) begin
      e.addr = model_pc;
      e.ep   = epoch;
      pend_q.push_back(e);
      model_pc = model_pc + 32'd4;
    end
    if (rd) begin
      epoch++;
      exp_q.delete();
      model_pc = tgt;
      halted   = tgt[1:0] != 2'b00;
      if (halted) begin
        p.pc  = tgt;
        p.ins = 32'h0000_0013;
        p.exc = 1'b1;
        exp_q.push_back(p);
      end
    end
  endtask

  // Monitor: compare the decode-side packet with the scoreboard head.
  initial begin
    forever begin
      @(negedge clk_i);
      #4;
      if (rst_ni) begin
        chk1("valid", if_valid_o, exp_q.size() != 0);
        if (if_valid_o && exp_q.size() != 0) begin
          chk32("pc", if_pc_o, exp_q[0].pc);
          chk32("instr", if_instr_o, exp_q[0].ins);
          chk1("exc", if_exc_o, exp_q[0].exc);
          if (if_ready_i && !redirect_i) begin
            void'(exp_q.pop_front());
            delivered++;
          end
        end
      end
    end
  end

  initial begin
    bit          ok;
    bit          rd;
    logic [31:0] t;
    #1;
    chk1("rst_req", imem_req_o, 1'b0);
    chk1("rst_valid", if_valid_o, 1'b0);
    chk32("rst_addr", imem_addr_o, RESET_PC);
    chk32("rst_pc", if_pc_o, 32'h0);
    chk32("rst_instr", if_instr_o, 32'h0);
    chk1("rst_exc", if_exc_o, 1'b0);
    @(negedge clk_i);
    #2 rst_ni = 1'b1;

    // Streaming, then decode backpressure.
    repeat (12) cycle(0, 0, 1, 1, 1);
    repeat (10) cycle(0, 0, 1, 1, 0);
    repeat (8) cycle(0, 0, 1, 1, 1);

    // Redirect with requests in flight and one packet buffered.
    repeat (2) cycle(0, 0, 1, 0, 0);
    cycle(1, 32'h100, 1, 0, 0);
    repeat (8) cycle(0, 0, 1, 1, 1);

    // Redirect coinciding with the only outstanding response.
    repeat (5) cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 1, 0, 1);
    cycle(1, 32'h200, 0, 1, 1);
    repeat (6) cycle(0, 0, 1, 1, 1);

    // Misaligned target halts; aligned target resumes.
    cycle(1, 32'h102, 1, 1, 0);
    repeat (4) cycle(0, 0, 1, 1, 1);
    cycle(1, 32'h300, 1, 1, 1);
    repeat (6) cycle(0, 0, 1, 1, 1);

    // PC wrap across 2^32.
    cycle(1, 32'hFFFF_FFF8, 1, 1, 1);
    repeat (8) cycle(0, 0, 1, 1, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rd = halted ? ($urandom_range(0, 3) == 0)
                  : ($urandom_range(0, 23) == 0);
      t = {14'h0, 16'($urandom), 2'b00};
      if ($urandom_range(0, 4) == 0)
        t[1:0] = 2'($urandom_range(1, 3));
      cycle(rd, t, $urandom_range(0, 3) != 0, 2,
            $urandom_range(0, 3) != 0);
    end

    // Fill three entries, then reset mid-stream.
    repeat (6) cycle(0, 0, 0, 1, 1);
    cycle(1, 32'h400, 1, 1, 0);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      cycle(0, 0, 1, 1, 0);
      ok = exp_q.size() >= 3;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL fill_timeout act=%0d exp=3", exp_q.size());
    end
    @(negedge clk_i);
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    redirect_i    = 1'b0;
    #2 rst_ni = 1'b0;
    pend_q.delete();
    exp_q.delete();
    model_pc = RESET_PC;
    halted   = 1'b0;
    epoch++;
    #1;
    chk1("mid_rst_valid", if_valid_o, 1'b0);
    chk1("mid_rst_req", imem_req_o, 1'b0);
    chk32("mid_rst_addr", imem_addr_o, RESET_PC);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (12) cycle(0, 0, 1, 1, 1);

    chk1("progress", delivered > 200, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
